decode_stage_p: RTL and testbench
=================================

# decode_stage_p

Parametrised successor of the RV32 decode stage. It decodes the instruction held in the IF/ID register and reads operands from an internal register file with write-through bypass from write-back. It detects load-use hazards and drives the ID/EX pipeline register, which supports valid tracking, stall, flush and bubble insertion. It sits between the fetch register and the execute stage, and reuses the existing `control_unit` and `extend` modules unchanged.

## Interface

**Parameters**
- `XLEN`, default 32: datapath width for pc, operands and immediate.
- `NUM_REGS`, default 32: architectural register count. Legal values are 16 (RV32E) and 32.
- `CNT_W`, default 16: width of the bubble counter.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `arst_n`, in, 1: asynchronous, active-low reset.
- `flush_e`, in, 1: squash the instruction entering EX (branch/jump redirect).
- `stall_e`, in, 1: hold the ID/EX register contents.
- `valid_d`, in, 1: the IF/ID register holds a real instruction.
- `instr_d`, in, 32: instruction word.
- `pc_d`, `pc_plus4_d`, in, XLEN: fetch-side pc values.
- `reg_write_w`, in, 1: write-back write enable.
- `rd_w`, in, 5: write-back destination.
- `result_w`, in, XLEN: write-back data.
- `valid_e`, out, 1: EX slot holds a real instruction.
- `pc_e`, `pc_plus4_e`, out, XLEN: registered pc values.
- `jump_e`, `branch_e`, `mem_write_e`, `alu_src_e`, `reg_write_e`, out, 1: registered controls.
- `result_src_e`, out, 2: registered control.
- `alu_control_e`, out, 3: registered control.
- `rs1_e`, `rs2_e`, `rd_e`, out, 5: registered register indices.
- `rd1_e`, `rd2_e`, `imm_ext_e`, out, XLEN: registered operands and immediate.
- `load_use_hz`, out, 1: combinational; fetch and IF/ID must hold this cycle.
- `bubble_cnt`, out, CNT_W: saturating count of bubbles inserted.

## Operation

**Decode**
- `rs1_d = instr_d[19:15]`, `rs2_d = instr_d[24:20]`, `rd_d = instr_d[11:7]`.
- Controls and `imm_src` come from `control_unit`.
- The 32-bit `extend` output is sign-extended to XLEN.

**Register file**
- NUM_REGS x XLEN.
- Write at the rising edge when `reg_write_w & rd_w != 0 & rd_w < NUM_REGS`. All other writes are dropped.
- Reading x0, or any index >= NUM_REGS, returns 0.
- Bypass: if `reg_write_w & rd_w == rsN_d & rsN_d != 0`, then `rdN_d = result_w` in the same cycle.

**Load-use hazard**
- `load_use_hz = valid_d & valid_e & reg_write_e & result_src_e == 2'b01 & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d)`.
- Both source fields are always compared, regardless of instruction format.
- `load_use_hz` is gated off while `stall_e` is high.

**ID/EX register update, priority highest first**
1. `!arst_n`: clear everything.
2. `flush_e`: load a bubble.
3. `stall_e`: hold all outputs.
4. `load_use_hz`: load a bubble.
5. Otherwise: load the decoded values, with `valid_e <= valid_d`.

**Bubble**
- `valid_e = 0`.
- Every control output = 0, so there are no side effects.
- Indices, operands, pc and immediate = 0.

**Bubble counter**
- Increments by 1 on each cycle where case 2 or case 4 loads a bubble.
- Saturates at all-ones.
- Not affected by `stall_e`.

## Timing

**Reset**
- Every registered output is 0 immediately on `arst_n` low, without waiting for a clock edge.
- The register file clears to 0 and `bubble_cnt` clears to 0.
- Reset release is synchronised externally. The first capture happens at the first rising edge with `arst_n` high.

**Latency**
- Decode to EX outputs: 1 cycle.
- Write-back to a read of the same register: 0 cycles (bypass).

**Hazard**
- `load_use_hz` is valid in the same cycle as the offending D instruction.
- The next edge loads a bubble.
- On the following cycle `load_use_hz` is 0, because `valid_e` is now 0. The held D instruction then advances.

**Simultaneous events**
- `flush_e` and `stall_e` together: flush wins, and the counter increments once.
- `flush_e` and `load_use_hz` together: one bubble, one increment.
- Write-back to a register while D reads it: the bypass value is used. The register file updates at the same edge.

**Reset mid-operation**
- Asynchronous clear of all state. No partial updates.

## Test plan

- **Reset:** hold `arst_n=0` with random inputs. All outputs and `bubble_cnt` must be 0. After release, reads of x1..x31 return 0.
- **Bypass:** `reg_write_w=1`, `rd_w=5`, `result_w=0xDEADBEEF`, `instr_d = add x6,x5,x0`. After the next edge, `rd1_e=0xDEADBEEF`. A write to x0 with 0x1234 reads back 0.
- **Load-use:**
  - Cycle n: `lw x5,0(x1)` enters EX.
  - Cycle n+1: D holds `add x7,x5,x2`, so `load_use_hz=1`.
  - After that edge: `valid_e=0`, `reg_write_e=0`, `bubble_cnt=1`.
  - Next edge: the add reaches EX with `valid_e=1`.
- **Flush vs stall:** `flush_e=1` and `stall_e=1` with a valid add in D. EX becomes a bubble and `bubble_cnt` increments by 1. Next, `stall_e` alone for 3 cycles: outputs unchanged, `bubble_cnt` unchanged.
- **RV32E (`NUM_REGS=16`):** write 0x55 to x20, then read x20. The result must be 0, and x4 must be unchanged.
- **Counter saturation (`CNT_W=2`):** issue 5 consecutive flushes. `bubble_cnt` steps 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/decode_stage_p.sv
// Decode stage: RV32 control decode, register file with write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.

// Main decoder plus ALU decoder for the RV32 subset used by this core.
module control_unit (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       mem_write,
  output logic       jump,
  output logic       branch,
  output logic       alu_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);
  logic [1:0] alu_op;

  // Main decode: opcode to datapath controls
  always_comb begin
    reg_write = 1'b0; result_src = 2'b00; mem_write = 1'b0; jump = 1'b0;
    branch = 1'b0; alu_src = 1'b0; imm_src = 2'b00; alu_op = 2'b00;
    case (op)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_src = 2'b01; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin branch = 1'b1; imm_src = 2'b10; alu_op = 2'b01; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1101111: begin reg_write = 1'b1; jump = 1'b1; imm_src = 2'b11; result_src = 2'b10; end
      default: ;
    endcase
  end

  // ALU decode: sub only for R-type with funct7[5] set
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// Immediate generator: I, S, B, J formats, 32-bit sign-extended.
module extend (
  input  logic [31:7] instr,
  input  logic [1:0]  imm_src,
  output logic [31:0] imm_ext
);
  // Format select
  always_comb begin
    case (imm_src)
      2'b00:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      2'b01:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end
endmodule

module decode_stage_p #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush_e,
  input  logic             stall_e,
  input  logic             valid_d,
  input  logic [31:0]      instr_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic             reg_write_w,
  input  logic [4:0]       rd_w,
  input  logic [XLEN-1:0]  result_w,
  output logic             valid_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic             jump_e,
  output logic             branch_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             reg_write_e,
  output logic [1:0]       result_src_e,
  output logic [2:0]       alu_control_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic             load_use_hz,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int         AW    = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  typedef struct packed {
    logic            valid, jump, branch, mem_write, alu_src, reg_write;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pc_plus4;
  } idex_t;

  idex_t           dec, ex;
  logic [XLEN-1:0] rf [NUM_REGS];
  logic [4:0]      rs1_d, rs2_d;
  logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]      result_src_d, imm_src_d;
  logic [2:0]      alu_control_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;
  logic            rf_we, bubble;

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];

  control_unit u_ctl (
    .op(instr_d[6:0]), .funct3(instr_d[14:12]), .funct7b5(instr_d[30]),
    .reg_write(reg_write_d), .result_src(result_src_d), .mem_write(mem_write_d),
    .jump(jump_d), .branch(branch_d), .alu_src(alu_src_d), .imm_src(imm_src_d),
    .alu_control(alu_control_d)
  );

  extend u_ext (.instr(instr_d[31:7]), .imm_src(imm_src_d), .imm_ext(imm32));

  generate
    if (XLEN > 32) begin : g_sext
      assign imm_d = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_trunc
      assign imm_d = imm32[XLEN-1:0];
    end
  endgenerate

  // Same-cycle write-back wins; x0 and out-of-range indices read as zero.
  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] rs);
    if (reg_write_w && rs != 5'd0 && rd_w == rs) return result_w;
    if (rs == 5'd0 || {1'b0, rs} >= NREGS)        return '0;
    return rf[rs[AW-1:0]];
  endfunction

  // Writes to x0 or past the implemented register count are dropped, so a
  // truncated index can never alias onto a low register.
  assign rf_we = reg_write_w && rd_w != 5'd0 && {1'b0, rd_w} < NREGS;

  // Register file write port
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rd_w[AW-1:0]] <= result_w;
    end
  end

  // Assemble the decoded ID/EX payload
  always_comb begin
    dec             = '0;
    dec.valid       = valid_d;
    dec.jump        = jump_d;
    dec.branch      = branch_d;
    dec.mem_write   = mem_write_d;
    dec.alu_src     = alu_src_d;
    dec.reg_write   = reg_write_d;
    dec.result_src  = result_src_d;
    dec.alu_control = alu_control_d;
    dec.rs1         = rs1_d;
    dec.rs2         = rs2_d;
    dec.rd          = instr_d[11:7];
    dec.rd1         = rd_port(rs1_d);
    dec.rd2         = rd_port(rs2_d);
    dec.imm         = imm_d;
    dec.pc          = pc_d;
    dec.pc_plus4    = pc_plus4_d;
  end

  // Both source fields are compared even for formats without rs2; a false
  // stall costs one bubble, a missed one corrupts data.
  assign load_use_hz = !stall_e && valid_d && ex.valid && ex.reg_write &&
                       ex.result_src == 2'b01 && ex.rd != 5'd0 &&
                       (ex.rd == rs1_d || ex.rd == rs2_d);

  // Flush beats stall; load_use_hz is already off while stalled.
  assign bubble = flush_e || load_use_hz;

  // ID/EX register: bubble, hold or capture
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)       ex <= '0;
    else if (bubble)   ex <= '0;
    else if (!stall_e) ex <= dec;
  end

  // Saturating bubble counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                           bubble_cnt <= '0;
    else if (bubble && bubble_cnt != '1)   bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  assign valid_e       = ex.valid;
  assign jump_e        = ex.jump;
  assign branch_e      = ex.branch;
  assign mem_write_e   = ex.mem_write;
  assign alu_src_e     = ex.alu_src;
  assign reg_write_e   = ex.reg_write;
  assign result_src_e  = ex.result_src;
  assign alu_control_e = ex.alu_control;
  assign rs1_e         = ex.rs1;
  assign rs2_e         = ex.rs2;
  assign rd_e          = ex.rd;
  assign rd1_e         = ex.rd1;
  assign rd2_e         = ex.rd2;
  assign imm_ext_e     = ex.imm;
  assign pc_e          = ex.pc;
  assign pc_plus4_e    = ex.pc_plus4;
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: default build (a) plus an RV32E build with a
// 2-bit bubble counter (b), both fed the same stimulus.
module tb_decode_stage_p;
  logic        clk = 1'b0;
  logic        arst_n, flush_e, stall_e, valid_d, reg_write_w;
  logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
  logic [4:0]  rd_w;

  logic        valid_e, jump_e, branch_e, mem_write_e, alu_src_e, reg_write_e, load_use_hz;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e;
  logic [15:0] bubble_cnt;

  logic        valid_e_b, jump_e_b, branch_e_b, mem_write_e_b, alu_src_e_b, reg_write_e_b, load_use_hz_b;
  logic [1:0]  result_src_e_b;
  logic [2:0]  alu_control_e_b;
  logic [4:0]  rs1_e_b, rs2_e_b, rd_e_b;
  logic [31:0] pc_e_b, pc_plus4_e_b, rd1_e_b, rd2_e_b, imm_ext_e_b;
  logic [1:0]  bubble_cnt_b;

  typedef struct packed {
    logic        valid, jump, branch, mem_write, alu_src, reg_write;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, pc, pc4;
    logic [15:0] bcnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  logic [15:0] bc;

  always #5 clk = ~clk;

  decode_stage_p u_a (
    .clk(clk), .arst_n(arst_n), .flush_e(flush_e), .stall_e(stall_e), .valid_d(valid_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .valid_e(valid_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .jump_e(jump_e), .branch_e(branch_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .load_use_hz(load_use_hz), .bubble_cnt(bubble_cnt)
  );

  decode_stage_p #(.XLEN(32), .NUM_REGS(16), .CNT_W(2)) u_b (
    .clk(clk), .arst_n(arst_n), .flush_e(flush_e), .stall_e(stall_e), .valid_d(valid_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .valid_e(valid_e_b), .pc_e(pc_e_b), .pc_plus4_e(pc_plus4_e_b),
    .jump_e(jump_e_b), .branch_e(branch_e_b), .mem_write_e(mem_write_e_b), .alu_src_e(alu_src_e_b),
    .reg_write_e(reg_write_e_b), .result_src_e(result_src_e_b), .alu_control_e(alu_control_e_b),
    .rs1_e(rs1_e_b), .rs2_e(rs2_e_b), .rd_e(rd_e_b), .rd1_e(rd1_e_b), .rd2_e(rd2_e_b),
    .imm_ext_e(imm_ext_e_b), .load_use_hz(load_use_hz_b), .bubble_cnt(bubble_cnt_b)
  );

  function automatic exp_t obs_a();
    exp_t o;
    o.valid = valid_e; o.jump = jump_e; o.branch = branch_e; o.mem_write = mem_write_e;
    o.alu_src = alu_src_e; o.reg_write = reg_write_e; o.result_src = result_src_e;
    o.alu_control = alu_control_e; o.rs1 = rs1_e; o.rs2 = rs2_e; o.rd = rd_e;
    o.rd1 = rd1_e; o.rd2 = rd2_e; o.pc = pc_e; o.pc4 = pc_plus4_e; o.bcnt = bubble_cnt;
    return o;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic exp_t ex_alu(input logic [4:0] rd, rs1, rs2, input logic [31:0] v1, v2, pc);
    exp_t e = '0;
    e.valid = 1'b1; e.reg_write = 1'b1; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.rd1 = v1; e.rd2 = v2; e.pc = pc; e.pc4 = pc + 32'd4; e.bcnt = bc;
    return e;
  endfunction

  function automatic exp_t ex_lw(input logic [4:0] rd, rs1, rs2, input logic [31:0] v1, v2, pc);
    exp_t e = ex_alu(rd, rs1, rs2, v1, v2, pc);
    e.result_src = 2'b01; e.alu_src = 1'b1;
    return e;
  endfunction

  function automatic exp_t ex_bub();
    exp_t e = '0;
    e.bcnt = bc;
    return e;
  endfunction

  task automatic set_d(input logic [31:0] instr, input logic [31:0] pc);
    instr_d = instr; pc_d = pc; pc_plus4_d = pc + 32'd4; valid_d = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t got, want;
    arst_n = 1'b1; reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'h77;
    set_d(enc_r(5'd4, 5'd3, 5'd3), 32'h40);
    sb.push_back(ex_alu(5'd4, 5'd3, 5'd3, 32'h77, 32'h77, 32'h40));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL pre_reset_load got=%h exp=%h", got, want); end
    reg_write_w = 1'b0;
    #2 arst_n = 1'b0; #1;
    got = obs_a(); total++;
    if (got !== '0 || imm_ext_e !== 32'h0) begin
      bad++; $display("FAIL async_clear got=%h imm=%h exp=0", got, imm_ext_e);
    end
    repeat (4) begin
      instr_d = $urandom; pc_d = $urandom; pc_plus4_d = $urandom; result_w = $urandom;
      rd_w = 5'($urandom); {flush_e, stall_e, valid_d, reg_write_w} = 4'($urandom);
      step(); got = obs_a(); total++;
      if (got !== '0 || imm_ext_e !== 32'h0 || load_use_hz !== 1'b0) begin
        bad++; $display("FAIL reset_hold_a got=%h imm=%h hz=%b exp=0", got, imm_ext_e, load_use_hz);
      end
      total++;
      if ({valid_e_b, jump_e_b, branch_e_b, mem_write_e_b, alu_src_e_b, reg_write_e_b, result_src_e_b,
           alu_control_e_b, rs1_e_b, rs2_e_b, rd_e_b, pc_e_b, pc_plus4_e_b, rd1_e_b, rd2_e_b,
           imm_ext_e_b, load_use_hz_b, bubble_cnt_b} !== '0) begin
        bad++; $display("FAIL reset_hold_b valid=%b rd1=%h cnt=%0d exp=0", valid_e_b, rd1_e_b, bubble_cnt_b);
      end
    end
    flush_e = 1'b0; stall_e = 1'b0; reg_write_w = 1'b0; arst_n = 1'b1; bc = '0;
    for (int i = 1; i < 32; i++) begin
      set_d(enc_r(5'd0, 5'(i), 5'(i)), 32'(i * 4));
      sb.push_back(ex_alu(5'd0, 5'(i), 5'(i), 32'h0, 32'h0, 32'(i * 4)));
      step(); got = obs_a(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL rf_clear x%0d got=%h exp=%h", i, got, want); end
      total++;
      if ({rd1_e_b, rd2_e_b} !== 64'h0) begin
        bad++; $display("FAIL rf_clear_b x%0d got=%h/%h exp=0", i, rd1_e_b, rd2_e_b);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t got, want;
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEADBEEF;
    set_d(enc_r(5'd6, 5'd5, 5'd0), 32'h100);
    sb.push_back(ex_alu(5'd6, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h100));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL bypass_rs1 got=%h exp=%h", got, want); end
    reg_write_w = 1'b0; set_d(enc_r(5'd6, 5'd5, 5'd0), 32'h104);
    sb.push_back(ex_alu(5'd6, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h104));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL rf_after_wb got=%h exp=%h", got, want); end
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h1234;
    set_d(enc_r(5'd6, 5'd0, 5'd0), 32'h108);
    sb.push_back(ex_alu(5'd6, 5'd0, 5'd0, 32'h0, 32'h0, 32'h108));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL x0_bypass got=%h exp=%h", got, want); end
    reg_write_w = 1'b1; rd_w = 5'd9; result_w = 32'hA5A5;
    set_d(enc_r(5'd1, 5'd0, 5'd9), 32'h10C);
    sb.push_back(ex_alu(5'd1, 5'd0, 5'd9, 32'h0, 32'hA5A5, 32'h10C));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL bypass_rs2 got=%h exp=%h", got, want); end
    reg_write_w = 1'b0; set_d(enc_r(5'd1, 5'd0, 5'd0), 32'h110);
    sb.push_back(ex_alu(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h110));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL x0_readback got=%h exp=%h", got, want); end
  endtask

  task automatic test_load_use();
    exp_t got, want;
    set_d(enc_lw(5'd5, 5'd1, 12'd0), 32'h200);
    sb.push_back(ex_lw(5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h200));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL lw_enter got=%h exp=%h", got, want); end
    set_d(enc_r(5'd7, 5'd5, 5'd2), 32'h204); #1; total++;
    if (load_use_hz !== 1'b1) begin bad++; $display("FAIL hz_rs1 got=%b exp=1", load_use_hz); end
    bc++; sb.push_back(ex_bub());
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL hz_bubble got=%h exp=%h", got, want); end
    total++;
    if (load_use_hz !== 1'b0) begin bad++; $display("FAIL hz_clears got=%b exp=0", load_use_hz); end
    sb.push_back(ex_alu(5'd7, 5'd5, 5'd2, 32'hDEADBEEF, 32'h0, 32'h204));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL hz_advance got=%h exp=%h", got, want); end
    set_d(enc_lw(5'd5, 5'd1, 12'd0), 32'h208);
    sb.push_back(ex_lw(5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h208));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL lw_enter2 got=%h exp=%h", got, want); end
    set_d(enc_r(5'd8, 5'd2, 5'd5), 32'h20C); stall_e = 1'b1; #1; total++;
    if (load_use_hz !== 1'b0) begin bad++; $display("FAIL hz_stall_gate got=%b exp=0", load_use_hz); end
    sb.push_back(ex_lw(5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h208));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL stall_hold_lw got=%h exp=%h", got, want); end
    stall_e = 1'b0; #1; total++;
    if (load_use_hz !== 1'b1) begin bad++; $display("FAIL hz_rs2 got=%b exp=1", load_use_hz); end
    bc++; sb.push_back(ex_bub());
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL hz_bubble2 got=%h exp=%h", got, want); end
    sb.push_back(ex_alu(5'd8, 5'd2, 5'd5, 32'h0, 32'hDEADBEEF, 32'h20C));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL hz_advance2 got=%h exp=%h", got, want); end
    set_d(enc_lw(5'd0, 5'd1, 12'd0), 32'h210);
    sb.push_back(ex_lw(5'd0, 5'd1, 5'd0, 32'h0, 32'h0, 32'h210));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL lw_x0 got=%h exp=%h", got, want); end
    set_d(enc_r(5'd9, 5'd0, 5'd0), 32'h214); #1; total++;
    if (load_use_hz !== 1'b0) begin bad++; $display("FAIL hz_rd_x0 got=%b exp=0", load_use_hz); end
    sb.push_back(ex_alu(5'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h214));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL no_hz_pass got=%h exp=%h", got, want); end
  endtask

  task automatic test_flush_stall();
    exp_t got, want;
    set_d(enc_r(5'd10, 5'd5, 5'd9), 32'h300);
    sb.push_back(ex_alu(5'd10, 5'd5, 5'd9, 32'hDEADBEEF, 32'hA5A5, 32'h300));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL fs_load got=%h exp=%h", got, want); end
    flush_e = 1'b1; stall_e = 1'b1; set_d(enc_r(5'd11, 5'd5, 5'd5), 32'h304);
    bc++; sb.push_back(ex_bub());
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL flush_over_stall got=%h exp=%h", got, want); end
    flush_e = 1'b0; stall_e = 1'b0;
    sb.push_back(ex_alu(5'd11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h304));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL fs_reload got=%h exp=%h", got, want); end
    stall_e = 1'b1; set_d(enc_r(5'd12, 5'd9, 5'd9), 32'h308);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(ex_alu(5'd11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h304));
      step(); got = obs_a(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", k, got, want); end
    end
    stall_e = 1'b0;
    sb.push_back(ex_alu(5'd12, 5'd9, 5'd9, 32'hA5A5, 32'hA5A5, 32'h308));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL stall_release got=%h exp=%h", got, want); end
    set_d(enc_lw(5'd5, 5'd1, 12'd0), 32'h30C);
    sb.push_back(ex_lw(5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h30C));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL fl_lw got=%h exp=%h", got, want); end
    set_d(enc_r(5'd13, 5'd5, 5'd0), 32'h310); flush_e = 1'b1; #1; total++;
    if (load_use_hz !== 1'b1) begin bad++; $display("FAIL hz_with_flush got=%b exp=1", load_use_hz); end
    bc++; sb.push_back(ex_bub());
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL flush_and_hz got=%h exp=%h", got, want); end
    flush_e = 1'b0;
    sb.push_back(ex_alu(5'd13, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h310));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL fl_advance got=%h exp=%h", got, want); end
  endtask

  task automatic test_imm();
    exp_t got, want;
    logic [31:0] iq[$];
    logic [31:0] iexp;
    set_d(32'hFFC0A283, 32'h400);
    sb.push_back(ex_lw(5'd5, 5'd1, 5'd28, 32'h0, 32'h0, 32'h400)); iq.push_back(32'hFFFFFFFC);
    step(); got = obs_a(); want = sb.pop_front(); iexp = iq.pop_front(); total++;
    if (got !== want || imm_ext_e !== iexp) begin
      bad++; $display("FAIL imm_lw got=%h/%h exp=%h/%h", got, imm_ext_e, want, iexp);
    end
    set_d(32'h0020A423, 32'h404);
    want = ex_alu(5'd8, 5'd1, 5'd2, 32'h0, 32'h0, 32'h404);
    want.reg_write = 1'b0; want.mem_write = 1'b1; want.alu_src = 1'b1;
    sb.push_back(want); iq.push_back(32'h8);
    step(); got = obs_a(); want = sb.pop_front(); iexp = iq.pop_front(); total++;
    if (got !== want || imm_ext_e !== iexp) begin
      bad++; $display("FAIL imm_sw got=%h/%h exp=%h/%h", got, imm_ext_e, want, iexp);
    end
  endtask

  task automatic test_rv32e();
    exp_t got, want;
    reg_write_w = 1'b1; rd_w = 5'd4; result_w = 32'h44;
    set_d(enc_r(5'd0, 5'd0, 5'd0), 32'h500);
    step();
    rd_w = 5'd20; result_w = 32'h55;
    step();
    reg_write_w = 1'b0; set_d(enc_r(5'd1, 5'd20, 5'd4), 32'h508);
    sb.push_back(ex_alu(5'd1, 5'd20, 5'd4, 32'h55, 32'h44, 32'h508));
    step(); got = obs_a(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL rv32i_x20 got=%h exp=%h", got, want); end
    total++;
    if (rd1_e_b !== 32'h0) begin bad++; $display("FAIL rv32e_x20 got=%h exp=0", rd1_e_b); end
    total++;
    if (rd2_e_b !== 32'h44) begin bad++; $display("FAIL rv32e_x4 got=%h exp=44", rd2_e_b); end
  endtask

  task automatic test_saturation();
    exp_t got, want;
    logic [1:0] bq[$];
    logic [1:0] bexp;
    arst_n = 1'b0; step(); arst_n = 1'b1; bc = '0;
    total++;
    if (bubble_cnt !== 16'd0 || bubble_cnt_b !== 2'd0) begin
      bad++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", bubble_cnt, bubble_cnt_b);
    end
    flush_e = 1'b1; set_d(enc_r(5'd3, 5'd1, 5'd2), 32'h600);
    for (int k = 1; k <= 5; k++) begin
      bc++; sb.push_back(ex_bub()); bq.push_back((k > 3) ? 2'd3 : 2'(k));
      step(); got = obs_a(); want = sb.pop_front(); bexp = bq.pop_front(); total++;
      if (got !== want || bubble_cnt_b !== bexp) begin
        bad++; $display("FAIL sat_%0d got=%h cnt_b=%0d exp=%h cnt_b=%0d", k, got, bubble_cnt_b, want, bexp);
      end
    end
    flush_e = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; flush_e = 1'b0; stall_e = 1'b0; valid_d = 1'b0; instr_d = '0;
    pc_d = '0; pc_plus4_d = '0; reg_write_w = 1'b0; rd_w = '0; result_w = '0; bc = '0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_imm();
    test_rv32e();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
